// File: rtl/fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe
//
// Five-stage pipelined floating-point adder/subtractor, parametrised in
// exponent and fraction width (FP32 by default). Sits between the multiplier
// output and the accumulator register of the MAC datapath.
//
//   stage 1  align      : unpack, special-value decode, swap, align smaller op
//   stage 2  add        : effective add / subtract of the aligned significands
//   stage 3  lzd        : leading-zero count, carry-out detect
//   stage 4  normalise  : right shift on carry, else left shift (clamped)
//   stage 5  round      : round-to-nearest-even, overflow/underflow, result mux
//
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready      operand handshake (a, b, op_sub)
//   op_sub                   1: a-b, 0: a+b, sampled with the operands
//   a, b                     operands {sign, exponent, fraction}
//   out_valid / out_ready    result handshake
//   result                   rounded sum / difference
//   flag_ovf/unf/inv/inx     overflow, underflow (flushed), invalid, inexact
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready = !(out_valid & !out_ready); while it is low every stage
// holds (global stall, bubbles are kept), and result/flags stay stable until
// the consumer takes them. Results leave in issue order.
// ---------------------------------------------------------------------------
module fp_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 flag_ovf,
   output logic                 flag_unf,
   output logic                 flag_inv,
   output logic                 flag_inx
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int FW   = MAN_W + 1;           // significand incl. hidden bit
   localparam int AW   = MAN_W + 3;           // significand + guard + round
   localparam int SW   = MAN_W + 5;           // carry, significand, G, R, S
   localparam int LZ_W = $clog2(MAN_W + 5);
   localparam int EW   = EXP_W + 1;           // exponent with headroom

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

   logic adv;
   assign in_ready = !(out_valid && !out_ready);
   assign adv      = in_ready;

   // ------------------------------------------------------------------------
   // Stage 1: unpack, special values, swap and align
   // ------------------------------------------------------------------------
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_sign = a[W-1];
   assign b_sign = b[W-1] ^ op_sub;          // effective sign of b
   assign a_exp  = a[W-2:MAN_W];
   assign b_exp  = b[W-2:MAN_W];
   assign a_frac = a[MAN_W-1:0];
   assign b_frac = b[MAN_W-1:0];

   // Denormal inputs (exp = 0) are treated as signed zero.
   assign a_zero = (a_exp == '0);
   assign b_zero = (b_exp == '0);
   assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
   assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
   assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
   assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

   logic             swap;
   logic             x_sign;
   logic [EXP_W-1:0] x_exp, y_exp, diff, al_sh;
   logic [FW-1:0]    x_sig, y_sig;
   logic [2*AW-1:0]  al_wide;

   always_comb begin
      // Magnitude compare on {exponent, fraction} puts the larger op in X.
      swap   = (b[W-2:0] > a[W-2:0]);
      x_sign = a_sign;
      x_exp  = a_exp;
      y_exp  = b_exp;
      x_sig  = {1'b1, a_frac};
      y_sig  = {1'b1, b_frac};
      if (swap) begin
         x_sign = b_sign;
         x_exp  = b_exp;
         y_exp  = a_exp;
         x_sig  = {1'b1, b_frac};
         y_sig  = {1'b1, a_frac};
      end
      diff = x_exp - y_exp;
      // Past AW positions nothing but sticky survives; clamping keeps the
      // shifted-out bits inside the lower half so sticky is never lost.
      al_sh   = (int'(diff) > AW) ? EXP_W'(AW) : diff;
      al_wide = {y_sig, 2'b00, {AW{1'b0}}} >> al_sh;
   end

   logic         sp_hit, sp_inv;
   logic [W-1:0] sp_res;

   always_comb begin
      sp_hit = 1'b1;
      sp_inv = 1'b0;
      sp_res = '0;
      if (a_nan || b_nan) begin
         sp_res = QNAN;
      end else if (a_inf && b_inf) begin
         if (a_sign != b_sign) begin
            sp_res = QNAN;
            sp_inv = 1'b1;
         end else begin
            sp_res = {a_sign, EXP_ONES, {MAN_W{1'b0}}};
         end
      end else if (a_inf) begin
         sp_res = a;
      end else if (b_inf) begin
         sp_res = {b_sign, EXP_ONES, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         // -0 only when both effective signs are negative.
         sp_res = {a_sign & b_sign, {(W-1){1'b0}}};
      end else if (a_zero) begin
         sp_res = {b_sign, b[W-2:0]};
      end else if (b_zero) begin
         sp_res = a;
      end else begin
         sp_hit = 1'b0;
      end
   end

   logic             s1_v, s1_spec, s1_inv, s1_sign, s1_sub, s1_yst;
   logic [W-1:0]     s1_res;
   logic [EXP_W-1:0] s1_exp;
   logic [FW-1:0]    s1_mx;
   logic [AW-1:0]    s1_yal;

   // ------------------------------------------------------------------------
   // Stage 2: significand add / subtract (X >= Y so never negative)
   // ------------------------------------------------------------------------
   logic [SW-1:0] add_x, add_y, add_sum;

   always_comb begin
      add_x   = {1'b0, s1_mx, 3'b000};
      add_y   = {1'b0, s1_yal, s1_yst};
      add_sum = s1_sub ? (add_x - add_y) : (add_x + add_y);
   end

   logic             s2_v, s2_spec, s2_inv, s2_sign;
   logic [W-1:0]     s2_res;
   logic [EXP_W-1:0] s2_exp;
   logic [SW-1:0]    s2_mag;

   // ------------------------------------------------------------------------
   // Stage 3: leading-zero count below the carry position
   // ------------------------------------------------------------------------
   logic [LZ_W-1:0] lz_n;

   always_comb begin
      lz_n = LZ_W'(SW - 1);                  // all zero: exact cancellation
      for (int i = 0; i < SW - 1; i++) begin
         if (s2_mag[i]) lz_n = LZ_W'(SW - 2 - i);
      end
   end

   logic             s3_v, s3_spec, s3_inv, s3_sign, s3_carry, s3_zero;
   logic [W-1:0]     s3_res;
   logic [EXP_W-1:0] s3_exp;
   logic [SW-1:0]    s3_mag;
   logic [LZ_W-1:0]  s3_lz;

   // ------------------------------------------------------------------------
   // Stage 4: normalise
   // ------------------------------------------------------------------------
   logic [EW-1:0] nrm_exp, exp_ext;
   logic [SW-2:0] nrm_man;                   // hidden, fraction, G, R, S
   logic          nrm_unf;

   always_comb begin
      exp_ext = {1'b0, s3_exp};
      nrm_unf = 1'b0;
      if (s3_carry) begin
         // Right by one; the dropped LSB folds into sticky.
         nrm_man = {s3_mag[SW-1:2], s3_mag[1] | s3_mag[0]};
         nrm_exp = exp_ext + EW'(1);
      end else begin
         nrm_man = s3_mag[SW-2:0] << s3_lz;
         nrm_exp = exp_ext - EW'(s3_lz);
         // The shift would take the exponent below 1: flush as underflow.
         nrm_unf = !s3_zero && (int'(s3_lz) >= int'(s3_exp));
      end
   end

   logic          s4_v, s4_spec, s4_inv, s4_sign, s4_zero, s4_unf;
   logic [W-1:0]  s4_res;
   logic [EW-1:0] s4_exp;
   logic [SW-2:0] s4_man;

   // ------------------------------------------------------------------------
   // Stage 5: round to nearest even, final result and flags
   // ------------------------------------------------------------------------
   logic             rnd_g, rnd_r, rnd_s, rnd_lsb, rnd_inc, rnd_inx, rnd_ovf;
   logic [MAN_W+1:0] rnd_mant;
   logic [EW-1:0]    rnd_exp;
   logic [MAN_W-1:0] rnd_frac;
   logic [W-1:0]     res_n;
   logic             ovf_n, unf_n, inv_n, inx_n;

   always_comb begin
      rnd_lsb  = s4_man[3];
      rnd_g    = s4_man[2];
      rnd_r    = s4_man[1];
      rnd_s    = s4_man[0];
      rnd_inc  = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      rnd_inx  = rnd_g | rnd_r | rnd_s;
      rnd_mant = {1'b0, s4_man[SW-2:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
      // A carry out of rounding means the significand became 10.00..0.
      rnd_exp  = s4_exp + {{EXP_W{1'b0}}, rnd_mant[MAN_W+1]};
      rnd_frac = rnd_mant[MAN_W+1] ? rnd_mant[MAN_W:1] : rnd_mant[MAN_W-1:0];
      rnd_ovf  = (rnd_exp >= {1'b0, EXP_ONES});

      res_n = {s4_sign, rnd_exp[EXP_W-1:0], rnd_frac};
      ovf_n = 1'b0;
      unf_n = 1'b0;
      inv_n = 1'b0;
      inx_n = rnd_inx;
      if (s4_spec) begin
         res_n = s4_res;
         inv_n = s4_inv;
         inx_n = 1'b0;
      end else if (s4_zero) begin
         res_n = '0;                         // exact cancellation gives +0
         inx_n = 1'b0;
      end else if (s4_unf) begin
         res_n = {s4_sign, {(W-1){1'b0}}};
         unf_n = 1'b1;
         inx_n = 1'b1;
      end else if (rnd_ovf) begin
         res_n = {s4_sign, EXP_ONES, {MAN_W{1'b0}}};
         ovf_n = 1'b1;
         inx_n = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Valid bits and output register (reset), datapath registers (no reset)
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         s3_v      <= 1'b0;
         s4_v      <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         flag_ovf  <= 1'b0;
         flag_unf  <= 1'b0;
         flag_inv  <= 1'b0;
         flag_inx  <= 1'b0;
      end else if (adv) begin
         s1_v      <= in_valid;
         s2_v      <= s1_v;
         s3_v      <= s2_v;
         s4_v      <= s3_v;
         out_valid <= s4_v;
         result    <= s4_v ? res_n : '0;
         flag_ovf  <= s4_v & ovf_n;
         flag_unf  <= s4_v & unf_n;
         flag_inv  <= s4_v & inv_n;
         flag_inx  <= s4_v & inx_n;
      end
   end

   always_ff @(posedge clock) begin
      if (adv) begin
         s1_spec  <= sp_hit;
         s1_inv   <= sp_inv;
         s1_res   <= sp_res;
         s1_sign  <= x_sign;
         s1_sub   <= a_sign ^ b_sign;
         s1_exp   <= x_exp;
         s1_mx    <= x_sig;
         s1_yal   <= al_wide[2*AW-1:AW];
         s1_yst   <= |al_wide[AW-1:0];

         s2_spec  <= s1_spec;
         s2_inv   <= s1_inv;
         s2_res   <= s1_res;
         s2_sign  <= s1_sign;
         s2_exp   <= s1_exp;
         s2_mag   <= add_sum;

         s3_spec  <= s2_spec;
         s3_inv   <= s2_inv;
         s3_res   <= s2_res;
         s3_sign  <= s2_sign;
         s3_exp   <= s2_exp;
         s3_mag   <= s2_mag;
         s3_lz    <= lz_n;
         s3_carry <= s2_mag[SW-1];
         s3_zero  <= (s2_mag == '0);

         s4_spec  <= s3_spec;
         s4_inv   <= s3_inv;
         s4_res   <= s3_res;
         s4_sign  <= s3_sign;
         s4_zero  <= s3_zero;
         s4_unf   <= nrm_unf;
         s4_exp   <= nrm_exp;
         s4_man   <= nrm_man;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_fp_addsub_pipe
//
// Directed bench for fp_addsub_pipe: an FP32 instance and a half-precision
// (EXP_W=5, MAN_W=10) instance share the clock and reset. Expected values are
// hand-computed IEEE encodings. Flags are compared as {ovf, unf, inv, inx}.
// ---------------------------------------------------------------------------
module tb_fp_addsub_pipe;

   // ---------------- clock / reset ----------------
   logic clock;
   logic resetn;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // ---------------- FP32 instance ----------------
   logic        in_valid, in_ready, op_sub, out_valid, out_ready;
   logic [31:0] a, b, result;
   logic        flag_ovf, flag_unf, flag_inv, flag_inx;

   fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_ovf  (flag_ovf),
      .flag_unf  (flag_unf),
      .flag_inv  (flag_inv),
      .flag_inx  (flag_inx)
   );

   // ---------------- half-precision instance ----------------
   logic        h_in_valid, h_in_ready, h_op_sub, h_out_valid, h_out_ready;
   logic [15:0] h_a, h_b, h_result;
   logic        h_flag_ovf, h_flag_unf, h_flag_inv, h_flag_inx;

   fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (h_in_valid),
      .in_ready  (h_in_ready),
      .op_sub    (h_op_sub),
      .a         (h_a),
      .b         (h_b),
      .out_valid (h_out_valid),
      .out_ready (h_out_ready),
      .result    (h_result),
      .flag_ovf  (h_flag_ovf),
      .flag_unf  (h_flag_unf),
      .flag_inv  (h_flag_inv),
      .flag_inx  (h_flag_inx)
   );

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   // ---------------- driver tasks ----------------
   // Issue one FP32 op with out_ready high; return the first output seen and
   // the latency in rising edges counted from (and including) the accept edge.
   task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, output logic [31:0] res,
                        output logic [3:0] flg, output int lat);
      @(negedge clock);
      a         = ta;
      b         = tb_v;
      op_sub    = ts;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clock);
      lat = 1;
      @(negedge clock);
      in_valid = 1'b0;
      while (!out_valid && lat < 20) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      res = result;
      flg = {flag_ovf, flag_unf, flag_inv, flag_inx};
   endtask

   task automatic do_op_h(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic ts, output logic [15:0] res,
                          output logic [3:0] flg, output int lat);
      @(negedge clock);
      h_a         = ta;
      h_b         = tb_v;
      h_op_sub    = ts;
      h_in_valid  = 1'b1;
      h_out_ready = 1'b1;
      @(posedge clock);
      lat = 1;
      @(negedge clock);
      h_in_valid = 1'b0;
      while (!h_out_valid && lat < 20) begin
         @(posedge clock);
         lat++;
         @(negedge clock);
      end
      res = h_result;
      flg = {h_flag_ovf, h_flag_unf, h_flag_inv, h_flag_inx};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      #13;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 ||
          {flag_ovf, flag_unf, flag_inv, flag_inx} !== 4'h0) begin
         errors++;
         $display("FAIL reset_outputs: out_valid=%b result=%h flags=%b, need 0/00000000/0000",
                  out_valid, result, {flag_ovf, flag_unf, flag_inv, flag_inx});
      end
      checks++;
      if (in_ready !== 1'b1 || h_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready: in_ready=%b h_in_ready=%b, need 1/1", in_ready, h_in_ready);
      end
      checks++;
      if (h_out_valid !== 1'b0 || h_result !== 16'h0) begin
         errors++;
         $display("FAIL reset_half: out_valid=%b result=%h, need 0/0000", h_out_valid, h_result);
      end
      @(posedge clock);
      #2 resetn = 1'b1;
   endtask

   // FP32 directed vectors: a, b, op_sub, expected result, expected flags.
   task automatic test_vectors();
      localparam int N = 21;
      logic [31:0] va [N] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000,
                              32'h3F800000, 32'h3F800000, 32'h3F800001, 32'h3F800000,
                              32'h7F800000, 32'h7F7FFFFF, 32'h00400000, 32'h7FC00001,
                              32'h7F800000, 32'h3F800000, 32'h00000000, 32'h80000000,
                              32'h00000000, 32'h40490FDB, 32'h00C00000, 32'h80C00000,
                              32'h7F800000};
      logic [31:0] vb [N] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'hBF800000,
                              32'h33800000, 32'h34400000, 32'h33800000, 32'h0DA24260,
                              32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 32'h3F800000,
                              32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h00000000,
                              32'h80000000, 32'h00000000, 32'h00800000, 32'h80800000,
                              32'h7F800000};
      logic        vs [N] = '{1'b0, 1'b1, 1'b1, 1'b0,
                              1'b0, 1'b0, 1'b0, 1'b0,
                              1'b1, 1'b0, 1'b0, 1'b0,
                              1'b0, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b1,
                              1'b0};
      logic [31:0] vr [N] = '{32'h40000000, 32'h00000000, 32'hBF800000, 32'h40000000,
                              32'h3F800000, 32'h3F800002, 32'h3F800002, 32'h3F800000,
                              32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000,
                              32'h7F800000, 32'hFF800000, 32'hBF800000, 32'h80000000,
                              32'h00000000, 32'h40490FDB, 32'h00000000, 32'h80000000,
                              32'h7F800000};
      logic [3:0]  vf [N] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0001, 4'b0001, 4'b0001, 4'b0001,
                              4'b0010, 4'b1001, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b0000, 4'b0101, 4'b0101,
                              4'b0000};
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      for (int i = 0; i < N; i++) begin
         do_op(va[i], vb[i], vs[i], res, flg, lat);
         checks++;
         if (lat !== 5) begin
            errors++;
            $display("FAIL vec%0d_latency: got %0d edges, need 5", i, lat);
         end
         checks++;
         if (res !== vr[i]) begin
            errors++;
            $display("FAIL vec%0d_result: %h %s %h gave %h, need %h",
                     i, va[i], vs[i] ? "-" : "+", vb[i], res, vr[i]);
         end
         checks++;
         if (flg !== vf[i]) begin
            errors++;
            $display("FAIL vec%0d_flags: got %b, need %b (ovf,unf,inv,inx)", i, flg, vf[i]);
         end
      end
   endtask

   // 8 back-to-back ops, out_ready low in cycles 6..8 of the burst.
   task automatic test_back_to_back();
      logic [31:0] va [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40000000, 32'h3F800000, 32'h3F000000, 32'h40400000};
      logic [31:0] vb [8] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                              32'h40000000, 32'h40000000, 32'h3F000000, 32'h3F000000};
      logic        vs [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] vr [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40400000,
                              32'h40800000, 32'hBF800000, 32'h3F800000, 32'h40600000};
      int          issued = 0;
      int          received = 0;
      logic        stalled = 1'b0;
      logic        accept;
      logic [31:0] held = '0;
      logic [31:0] want;
      exp_q.delete();
      for (int cyc = 1; cyc <= 60 && received < 8; cyc++) begin
         @(negedge clock);
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || result !== held) begin
               errors++;
               $display("FAIL b2b_hold_c%0d: out_valid=%b result=%h, need 1/%h",
                        cyc, out_valid, result, held);
            end
         end
         out_ready = !(cyc >= 6 && cyc <= 8);
         if (issued < 8) begin
            in_valid = 1'b1;
            a        = va[issued];
            b        = vb[issued];
            op_sub   = vs[issued];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         checks++;
         if (in_ready !== !(cyc >= 6 && cyc <= 8)) begin
            errors++;
            $display("FAIL b2b_in_ready_c%0d: got %b, need %b",
                     cyc, in_ready, !(cyc >= 6 && cyc <= 8));
         end
         checks++;
         if (out_valid !== (cyc >= 6 && cyc <= 16)) begin
            errors++;
            $display("FAIL b2b_out_valid_c%0d: got %b, need %b",
                     cyc, out_valid, (cyc >= 6 && cyc <= 16));
         end
         if (out_valid && out_ready) begin
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEADBEEF;
            checks++;
            if (result !== want || {flag_ovf, flag_unf, flag_inv, flag_inx} !== 4'h0) begin
               errors++;
               $display("FAIL b2b_result%0d: got %h flags %b, need %h flags 0000",
                        received, result, {flag_ovf, flag_unf, flag_inv, flag_inx}, want);
            end
            received++;
         end
         stalled = out_valid && !out_ready;
         held    = result;
         accept  = in_valid && in_ready;
         @(posedge clock);
         if (accept) begin
            exp_q.push_back(vr[issued]);
            issued++;
         end
      end
      @(negedge clock);
      in_valid = 1'b0;
      checks++;
      if (received !== 8 || exp_q.size() !== 0) begin
         errors++;
         $display("FAIL b2b_count: received %0d, pending %0d, need 8/0", received, exp_q.size());
      end
      for (int k = 0; k < 6; k++) begin
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_extra_output: out_valid=%b result=%h after drain, need 0",
                     out_valid, result);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_half();
      logic [15:0] va [5] = '{16'h3C00, 16'h7BFF, 16'h3C00, 16'h3C00, 16'h3C00};
      logic [15:0] vb [5] = '{16'h3C00, 16'h7BFF, 16'h3C00, 16'h1400, 16'h1000};
      logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] vr [5] = '{16'h4000, 16'h7C00, 16'h0000, 16'h3C01, 16'h3C00};
      logic [3:0]  vf [5] = '{4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0001};
      logic [15:0] res;
      logic [3:0]  flg;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         do_op_h(va[i], vb[i], vs[i], res, flg, lat);
         checks++;
         if (lat !== 5 || res !== vr[i] || flg !== vf[i]) begin
            errors++;
            $display("FAIL half%0d: %h %s %h gave %h flags %b lat %0d, need %h flags %b lat 5",
                     i, va[i], vs[i] ? "-" : "+", vb[i], res, flg, lat, vr[i], vf[i]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] ops [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};
      logic [31:0] res;
      logic [3:0]  flg;
      int          lat;
      int          n;
      @(negedge clock);
      out_ready = 1'b0;
      op_sub    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a        = ops[i];
         b        = 32'h3F800000;
         in_valid = 1'b1;
         @(negedge clock);
      end
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_fill: out_valid=%b before reset, need 1", out_valid);
      end
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 32'h0 ||
          {flag_ovf, flag_unf, flag_inv, flag_inx} !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_async: out_valid=%b result=%h flags=%b in_ready=%b, need 0/0/0000/1",
                  out_valid, result, {flag_ovf, flag_unf, flag_inv, flag_inx}, in_ready);
      end
      repeat (2) @(posedge clock);
      #2 resetn = 1'b1;
      // 2.0 + 3.0 = 5.0, issued on the first rising edge after release.
      do_op(32'h40000000, 32'h40400000, 1'b0, res, flg, lat);
      checks++;
      if (lat !== 5 || res !== 32'h40A00000 || flg !== 4'h0) begin
         errors++;
         $display("FAIL mid_first_op: result %h flags %b lat %0d, need 40a00000 flags 0000 lat 5",
                  res, flg, lat);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale: out_valid=%b result=%h after release, need 0",
                     out_valid, result);
         end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      in_valid    = 1'b0;
      op_sub      = 1'b0;
      a           = '0;
      b           = '0;
      out_ready   = 1'b1;
      h_in_valid  = 1'b0;
      h_op_sub    = 1'b0;
      h_a         = '0;
      h_b         = '0;
      h_out_ready = 1'b1;

      test_reset();
      test_vectors();
      test_back_to_back();
      test_half();
      test_reset_midstream();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
